// File: rtl/axi_rd_arbiter_pkg.sv
// Purpose: shared AXI read-bus widths and payload types for the read arbiter slice.
// Latency: n/a (types, constants and one payload helper only).
// Backpressure: n/a.
package axi_rd_arbiter_pkg;

    localparam int unsigned NUM_MASTERS = 4;
    localparam int unsigned MID         = $clog2(NUM_MASTERS);
    localparam int unsigned NUM_U_READS = 4;
    localparam int unsigned ARADDR      = 32;
    localparam int unsigned ARID        = 2;
    localparam int unsigned ARID_MID    = ARID + MID;
    localparam int unsigned RDATA       = 64;
    localparam int unsigned RID         = ARID;
    localparam int unsigned RID_MID     = ARID_MID;

    typedef logic [ARID_MID-1:0] mid_t;
    typedef logic [1:0]          rresp_t;
    typedef logic [MID-1:0]      midx_t;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } ar_state_e;

    // AR payload. On the master side only mid_id[ARID-1:0] (the local id) is meaningful.
    typedef struct packed {
        logic [ARADDR-1:0] addr;
        logic [2:0]        size;
        logic [7:0]        len;
        logic [1:0]        burst;
        mid_t              mid_id;
    } ar_req_t;

    // R payload. Towards the masters mid_id carries only the local id (upper bits zero).
    typedef struct packed {
        logic [RDATA-1:0] data;
        logic             last;
        rresp_t           resp;
        mid_t             mid_id;
    } r_beat_t;

    // Replace whatever the master put in the upper id bits with its grant index.
    function automatic ar_req_t tag_req(ar_req_t r, midx_t m);
        ar_req_t t;
        t        = r;
        t.mid_id = {m, r.mid_id[ARID-1:0]};
        return t;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// Purpose: round-robin picker over the master request vector, one-hot + index grant.
// Latency: grant is combinational from req_i; priority pointer moves on the cycle after adv_i.
// Backpressure: none internally; the pointer only moves when the caller strobes adv_i.
module rr_arbiter
    import axi_rd_arbiter_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   adv_i,
    input  midx_t                  adv_idx_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output midx_t                  gnt_idx_o,
    output logic                   gnt_vld_o
);

    midx_t last_q;

    // Scan from the slot after the last winner; index wrap relies on NUM_MASTERS being a power of two.
    always_comb begin
        midx_t idx;
        logic  found;
        idx       = '0;
        found     = 1'b0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = last_q + midx_t'(k + 1);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_idx_o  = idx;
                gnt_o[idx] = 1'b1;
            end
        end
        gnt_vld_o = found;
    end

    // Remember the winner of each completed handshake; reset makes master 0 first in line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= midx_t'(NUM_MASTERS - 1);
        end else if (adv_i) begin
            last_q <= adv_idx_i;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Purpose: 4-master AXI read arbiter: RR on AR with {master,id} tagging, R routed by tag, per-master outstanding limit.
// Latency: AR 0 cycles (1 cycle with AXI_RD_AR_SLICE_EN defined), R 0 cycles.
// Backpressure: a stalled AR is held without re-arbitration; R ready comes straight from the owning master.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUT = NUM_U_READS
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic    [NUM_MASTERS-1:0]                      m_arvalid_i,
    output logic    [NUM_MASTERS-1:0]                      m_arready_o,
    input  ar_req_t [NUM_MASTERS-1:0]                      m_ar_i,
    output logic                                           s_arvalid_o,
    input  logic                                           s_arready_i,
    output ar_req_t                                        s_ar_o,
    input  logic                                           s_rvalid_i,
    output logic                                           s_rready_o,
    input  r_beat_t                                        s_r_i,
    output logic    [NUM_MASTERS-1:0]                      m_rvalid_o,
    input  logic    [NUM_MASTERS-1:0]                      m_rready_i,
    output r_beat_t                                        m_r_o,
    output logic    [NUM_MASTERS-1:0][$clog2(MAX_OUT+1)-1:0] outstanding_o,
    output logic                                           err_unexp_r_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [NUM_MASTERS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                              err_q, err_d;
    logic [NUM_MASTERS-1:0]            elig;
    logic [NUM_MASTERS-1:0]            rr_gnt;
    midx_t                             rr_idx;
    logic                              rr_vld;
    logic                              ar_hs;
    midx_t                             ar_idx;
    midx_t                             r_idx;
    logic                              r_last_hs;
    logic [NUM_MASTERS-1:0]            inc_v, dec_v;

    // A master competes only while it is below its outstanding-burst budget.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            elig[i] = m_arvalid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
        end
    end

    rr_arbiter u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (elig),
        .adv_i     (ar_hs),
        .adv_idx_i (ar_idx),
        .gnt_o     (rr_gnt),
        .gnt_idx_o (rr_idx),
        .gnt_vld_o (rr_vld)
    );

`ifdef AXI_RD_AR_SLICE_EN
    logic    slice_vld_q;
    ar_req_t slice_q;
    logic    slice_free;

    assign slice_free  = !slice_vld_q || s_arready_i;
    assign ar_hs       = rr_vld && slice_free;
    assign ar_idx      = rr_idx;
    assign m_arready_o = rr_gnt & {NUM_MASTERS{slice_free}};
    assign s_arvalid_o = slice_vld_q;
    assign s_ar_o      = slice_q;

    // One-entry slice: refilled by the winner whenever it is empty or emptying this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slice_vld_q <= 1'b0;
            slice_q     <= '0;
        end else if (ar_hs) begin
            slice_vld_q <= 1'b1;
            slice_q     <= tag_req(m_ar_i[rr_idx], rr_idx);
        end else if (s_arready_i) begin
            slice_vld_q <= 1'b0;
        end
    end
`else
    ar_state_e state_q;
    midx_t     hold_q;

    // Present the fresh winner in ARB, or the latched one in HOLD so valid/payload stay stable.
    always_comb begin
        s_arvalid_o = 1'b0;
        s_ar_o      = '0;
        m_arready_o = '0;
        ar_hs       = 1'b0;
        ar_idx      = '0;
        if (state_q == HOLD) begin
            s_arvalid_o         = 1'b1;
            s_ar_o              = tag_req(m_ar_i[hold_q], hold_q);
            m_arready_o[hold_q] = s_arready_i;
            ar_hs               = s_arready_i;
            ar_idx              = hold_q;
        end else if (rr_vld) begin
            s_arvalid_o = 1'b1;
            s_ar_o      = tag_req(m_ar_i[rr_idx], rr_idx);
            m_arready_o = rr_gnt & {NUM_MASTERS{s_arready_i}};
            ar_hs       = s_arready_i;
            ar_idx      = rr_idx;
        end
    end

    // Enter HOLD when the slave stalls a fresh grant; leave it on the handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (rr_vld && !s_arready_i) begin
                        state_q <= HOLD;
                        hold_q  <= rr_idx;
                    end
                end
                HOLD: begin
                    if (s_arready_i) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end
`endif

    assign r_idx     = s_r_i.mid_id[RID_MID-1:RID];
    assign r_last_hs = s_rvalid_i && s_rready_o && s_r_i.last;

    // Steer the R beat to its owner by tag; ready comes back from that owner only.
    always_comb begin
        m_rvalid_o        = '0;
        m_rvalid_o[r_idx] = s_rvalid_i;
        s_rready_o        = m_rready_i[r_idx];
        m_r_o             = s_r_i;
        m_r_o.mid_id      = {{MID{1'b0}}, s_r_i.mid_id[RID-1:0]};
    end

    // Count up on AR acceptance, down on last R beat; a simultaneous pair cancels; underflow flags an error.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        cnt_d = cnt_q;
        err_d = err_q;
        inc_v[ar_idx] = ar_hs;
        dec_v[r_idx]  = r_last_hs;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec_v[i] && !inc_v[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Outstanding counters and the sticky unexpected-response flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign err_unexp_r_o = err_q;

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Read-path interconnect stage between the four bus masters (I$, D$, SP0, SP1) and the single memory-side AXI read slave.
- Arbitrates AR requests round-robin and forms the global ID mid_id = {master_id, local id}.
- Routes R beats back to the owning master using the upper MID bits of the returned mid_id.
- Enforces the per-master outstanding-read limit NUM_U_READS.

Parameters:
- NUM_MASTERS, 4, number of read masters; MID = $clog2(NUM_MASTERS).
- MAX_OUT, NUM_U_READS (4), outstanding AR bursts allowed per master.
- ADDR_W, ARADDR (32), address width.
- DATA_W, RDATA (64), read data width.

Ports:
- CLK, in, 1, system clock.
- nRST, in, 1, asynchronous active-low reset.
- m_arvalid, in, NUM_MASTERS, per-master AR valid.
- m_arready, out, NUM_MASTERS, per-master AR ready.
- m_ar, in, NUM_MASTERS×{addr,id,size,len,burst}, per-master AR payload; mid_id fields of inputs are ignored.
- s_arvalid, out, 1, AR valid to slave.
- s_arready, in, 1, AR ready from slave.
- s_ar, out, {addr,size,len,burst,mid_id}, forwarded AR payload with mid_id = {grant index, id}.
- s_rvalid, in, 1, R valid from slave.
- s_rready, out, 1, R ready to slave.
- s_r, in, {data,last,resp,mid_id}, R beat from slave.
- m_rvalid, out, NUM_MASTERS, per-master R valid.
- m_rready, in, NUM_MASTERS, per-master R ready.
- m_r, out, {data,last,resp,id}, broadcast R payload; id = s_r.mid_id[RID-1:0].
- outstanding, out, NUM_MASTERS×$clog2(MAX_OUT+1), live per-master counters.
- err_unexp_r, out, 1, sticky: R beat received for a master with zero outstanding.

Behaviour:
- Reset values: all outputs 0; counters 0; RR pointer = 0 (master 0 has highest priority first); FSM in ARB.
- Eligible(i) = m_arvalid[i] && outstanding[i] < MAX_OUT.
- FSM ARB:
  - Pick the first eligible master starting at (last_grant+1) mod NUM_MASTERS.
  - Drive s_arvalid=1 and s_ar combinationally in the same cycle (0-cycle latency).
  - m_arready[g] = s_arready; all other m_arready bits are 0.
  - If s_arready: handshake; last_grant=g; stay in ARB.
  - Else: latch g and go to HOLD.
- FSM HOLD:
  - s_arvalid=1 from latched g; no re-arbitration, so AXI valid/payload stability holds.
  - On s_arready: handshake, last_grant=g, go to ARB.
  - Masters are required to hold arvalid once asserted; dropping it is a protocol violation and is not checked.
- Counters:
  - +1 on AR handshake for master g.
  - -1 on R handshake with last=1 for master r = s_r.mid_id[RID_MID-1:RID].
  - Both on the same master in the same cycle: unchanged.
  - Never exceed MAX_OUT (eligibility gate); never go below 0 (saturate at 0 and set err_unexp_r).
- R routing:
  - m_rvalid[r] = s_rvalid; all other bits 0.
  - s_rready = m_rready[r].
  - Purely combinational, 0 latency; interleaving across masters is allowed beat by beat.
- Reset mid-burst: all state cleared immediately; in-flight responses arriving after reset are routed normally and set err_unexp_r.

Optional Feature:
- AXI_RD_AR_SLICE_EN defined:
  - A 1-entry register slice sits on s_ar/s_arvalid.
  - Arbitration writes the slice when it is empty, or when it is draining in the same cycle.
  - m_arready[g] = slice free.
  - AR latency becomes 1 cycle; full throughput of 1 AR/cycle is kept.
  - The counter increments on the master-side handshake.
- Undefined: combinational path as described in Behaviour.

Decomposition:
- Shared AXI bus package supplies the widths (ARADDR, ARID, ARID_MID, RDATA, RID_MID, MID) and the mid_t and rresp_t types.
- Add to the same package:
  - ar_req_t: AR payload without valid/ready.
  - r_beat_t: R payload without valid/ready.
- Natural sub-module: rr_arbiter (NUM_MASTERS request vector in, one-hot grant out, advance strobe in).

Test Plan:
- Single request: master 2 arvalid, id=1, s_arready=1 → s_arvalid same cycle, s_ar.mid_id=4'b1001, outstanding[2]=1.
- Fairness: all four masters continuously valid, s_arready=1 → grants follow 0,1,2,3,0 on consecutive cycles.
- Backpressure: master 1 valid, s_arready=0 for 3 cycles while master 0 raises valid → s_ar stays master 1 (mid_id 4'b01xx) until ready; master 0 is granted next.
- Limit: master 3 issues 4 ARs with no R → 5th request stalled (m_arready[3]=0); R last with mid_id=4'b11xx → count 3, request accepted next cycle.
- R routing: len=3 burst to D$, m_rready[1] toggling → 4 beats delivered only on m_rvalid[1]; s_rready mirrors m_rready[1]; counter decrements on last only.
- Unexpected R: R last with mid_id=4'b0000 while outstanding[0]=0 → err_unexp_r=1 and sticky; counter stays 0.
